// File: rtl/pipe_stage_skid.sv
// Purpose : handshaked inter-stage pipeline register with a one-entry skid buffer,
//           flush (bubble insertion) and optional control gating on bubbles.
// Latency : 1 falling edge from accept to OutValid; 1 entry/cycle while OutReady=1.
// Backpr. : InReady = ~skid_valid (registered only); a stalled main entry parks the
//           next accepted entry in the skid slot, so no entry is ever lost.
//
// Ports:
//   Clk              clock; all state updates on the falling edge
//   Reset            synchronous, active-high; clears every field
//   Flush            drops both entries and clears ctrl; data/addr are kept
//   InValid/InReady  upstream handshake (accept = InValid & InReady)
//   CtrlIn/DataIn/WriteAddressIn    incoming entry
//   OutValid/OutReady               downstream handshake (release = OutValid & OutReady)
//   CtrlOut/DataOut/WriteAddressOut main entry; CtrlOut gated when GATE_CTRL=1
//   Count            occupancy 0..2 (main + skid)

module pipe_stage_skid #(
  parameter int CTRL_W    = 16,
  parameter int DATA_W    = 160,
  parameter int ADDR_W    = 5,
  parameter bit GATE_CTRL = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [ADDR_W-1:0] WriteAddressIn,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [CTRL_W-1:0] CtrlOut,
  output logic [DATA_W-1:0] DataOut,
  output logic [ADDR_W-1:0] WriteAddressOut,
  output logic [1:0]        Count
);

  // Main entry (drives the outputs)
  logic              m_vld_q,  m_vld_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;

  // Skid entry (holds the entry accepted while main was stalled)
  logic              s_vld_q,  s_vld_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;

  logic accept;
  logic release_m;
  logic m_free;

  // Ready is purely registered: no path from OutReady to InReady.
  assign InReady   = ~s_vld_q;
  assign accept    = InValid & InReady;
  assign release_m = m_vld_q & OutReady;
  // Main slot can take a new entry this edge (empty, or its entry is leaving).
  assign m_free    = ~m_vld_q | release_m;

  always_comb begin
    m_vld_d  = m_vld_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    m_addr_d = m_addr_q;
    s_vld_d  = s_vld_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    s_addr_d = s_addr_q;

    if (Flush) begin
      // Bubble insertion: drop both entries, clear ctrl, keep data/addr.
      m_vld_d  = 1'b0;
      s_vld_d  = 1'b0;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end else if (m_free) begin
      if (s_vld_q) begin
        // Skid entry is older than anything upstream; it goes first.
        // InReady is low here, so no accept can collide with this move.
        m_vld_d  = 1'b1;
        m_ctrl_d = s_ctrl_q;
        m_data_d = s_data_q;
        m_addr_d = s_addr_q;
        s_vld_d  = 1'b0;
      end else if (accept) begin
        m_vld_d  = 1'b1;
        m_ctrl_d = CtrlIn;
        m_data_d = DataIn;
        m_addr_d = WriteAddressIn;
      end else begin
        m_vld_d  = 1'b0;
      end
    end else if (accept) begin
      // Main stalled: park the new entry in the skid slot.
      s_vld_d  = 1'b1;
      s_ctrl_d = CtrlIn;
      s_data_d = DataIn;
      s_addr_d = WriteAddressIn;
    end
  end

  always_ff @(negedge Clk) begin
    if (Reset) begin
      m_vld_q  <= 1'b0;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      m_addr_q <= '0;
      s_vld_q  <= 1'b0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      s_addr_q <= '0;
    end else begin
      m_vld_q  <= m_vld_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      m_addr_q <= m_addr_d;
      s_vld_q  <= s_vld_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
      s_addr_q <= s_addr_d;
    end
  end

  assign OutValid        = m_vld_q;
  assign DataOut         = m_data_q;
  assign WriteAddressOut = m_addr_q;
  assign Count           = {1'b0, m_vld_q} + {1'b0, s_vld_q};

  // Bubbles must never assert RegWrite/MemWrite downstream.
  generate
    if (GATE_CTRL) begin : g_gate
      assign CtrlOut = m_vld_q ? m_ctrl_q : '0;
    end else begin : g_nogate
      assign CtrlOut = m_ctrl_q;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int CW = 16;
  localparam int DW = 160;
  localparam int AW = 5;

  logic          Clk;
  logic          Reset;
  logic          Flush;
  logic          InValid;
  logic [CW-1:0] CtrlIn;
  logic [DW-1:0] DataIn;
  logic [AW-1:0] WriteAddressIn;
  logic          OutReady;

  logic          in_rdy_g,  in_rdy_u;
  logic          out_vld_g, out_vld_u;
  logic [CW-1:0] ctrl_g,    ctrl_u;
  logic [DW-1:0] data_g,    data_u;
  logic [AW-1:0] addr_g,    addr_u;
  logic [1:0]    cnt_g,     cnt_u;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .ADDR_W(AW), .GATE_CTRL(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(in_rdy_g),
    .CtrlIn(CtrlIn), .DataIn(DataIn), .WriteAddressIn(WriteAddressIn),
    .OutValid(out_vld_g), .OutReady(OutReady), .CtrlOut(ctrl_g), .DataOut(data_g),
    .WriteAddressOut(addr_g), .Count(cnt_g));

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .ADDR_W(AW), .GATE_CTRL(1'b0)) dut_ng (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(in_rdy_u),
    .CtrlIn(CtrlIn), .DataIn(DataIn), .WriteAddressIn(WriteAddressIn),
    .OutValid(out_vld_u), .OutReady(OutReady), .CtrlOut(ctrl_u), .DataOut(data_u),
    .WriteAddressOut(addr_u), .Count(cnt_u));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: a 2-deep FIFO of entries plus the last entry that sat in
  // the output position (what the outputs show once the stage drains).
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
  } ent_t;

  ent_t          mq[$];
  logic [CW-1:0] l_c;
  logic [DW-1:0] l_d;
  logic [AW-1:0] l_a;

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic          e_vld;
    logic [1:0]    e_cnt;
    logic [CW-1:0] e_cg;
    e_vld = (mq.size() > 0);
    e_cnt = 2'(mq.size());
    e_cg  = e_vld ? l_c : '0;
    chk("OutValid",        DW'(out_vld_g), DW'(e_vld));
    chk("InReady",         DW'(in_rdy_g),  DW'(mq.size() < 2));
    chk("Count",           DW'(cnt_g),     DW'(e_cnt));
    chk("CtrlOut_gated",   DW'(ctrl_g),    DW'(e_cg));
    chk("CtrlOut_ungated", DW'(ctrl_u),    DW'(l_c));
    chk("DataOut",         data_g,         l_d);
    chk("WriteAddressOut", DW'(addr_g),    DW'(l_a));
    chk("OutValid_ng",     DW'(out_vld_u), DW'(e_vld));
    chk("Count_ng",        DW'(cnt_u),     DW'(e_cnt));
  endtask

  // Drive one set of inputs, advance one falling edge, update model, check.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic [AW-1:0] a, input logic ordy);
    logic acc, rel;
    ent_t e;
    Reset = rst; Flush = fl; InValid = iv;
    CtrlIn = c; DataIn = d; WriteAddressIn = a; OutReady = ordy;
    acc = iv && (mq.size() < 2);
    rel = (mq.size() > 0) && ordy;
    e.c = c; e.d = d; e.a = a;
    @(negedge Clk);
    #1;
    if (rst) begin
      mq.delete();
      l_c = '0; l_d = '0; l_a = '0;
    end else if (fl) begin
      mq.delete();
      l_c = '0;
    end else begin
      if (rel) void'(mq.pop_front());
      if (acc) mq.push_back(e);
      if (mq.size() > 0) begin
        l_c = mq[0].c; l_d = mq[0].d; l_a = mq[0].a;
      end
    end
    check_all();
  endtask

  function automatic logic [DW-1:0] rdata();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    vectors = 0; miscompares = 0;
    l_c = '0; l_d = '0; l_a = '0;
    Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    CtrlIn = '0; DataIn = '0; WriteAddressIn = '0;

    // Reset with a valid entry presented: it must not be captured.
    step(1, 0, 1, 16'hFFFF, {DW{1'b1}}, 5'h1F, 1);
    step(1, 0, 1, 16'hFFFF, {DW{1'b1}}, 5'h1F, 1);
    chk("reset_count_zero", DW'(cnt_g), DW'(0));

    // Stream A, B, C with OutReady=1.
    step(0, 0, 1, 16'h0001, DW'(32'h11), 5'd1, 1);
    step(0, 0, 1, 16'h0002, DW'(32'h22), 5'd2, 1);
    step(0, 0, 1, 16'h0003, DW'(32'h33), 5'd3, 1);
    step(0, 0, 0, 16'h0000, '0,          5'd0, 1);

    // Stall: A in M, B to skid, then drain with C resent on the second edge.
    step(0, 0, 1, 16'h00A0, DW'(32'hA), 5'd10, 0);
    step(0, 0, 1, 16'h00B0, DW'(32'hB), 5'd11, 0);
    step(0, 0, 1, 16'h00C0, DW'(32'hC), 5'd12, 0);  // refused: InReady=0
    // OutReady must not reach InReady combinationally.
    OutReady = 1'b1;
    #1;
    chk("InReady_no_comb_path", DW'(in_rdy_g), DW'(0));
    step(0, 0, 0, 16'h0000, '0,         5'd0,  1);
    step(0, 0, 1, 16'h00C0, DW'(32'hC), 5'd12, 1);
    step(0, 0, 0, 16'h0000, '0,         5'd0,  1);
    step(0, 0, 0, 16'h0000, '0,         5'd0,  1);

    // Flush with Count=2 while D is presented; then E alone.
    step(0, 0, 1, 16'h0011, DW'(32'h1), 5'd1, 0);
    step(0, 0, 1, 16'h0022, DW'(32'h2), 5'd2, 0);
    step(0, 1, 1, 16'h00DD, DW'(32'hD), 5'd13, 0);
    step(0, 0, 1, 16'h00EE, DW'(32'hE), 5'd14, 1);
    step(0, 0, 0, 16'h0000, '0,         5'd0,  1);

    // Ctrl gating: hold 0x0005, then drain with no new input.
    step(0, 0, 1, 16'h0005, DW'(32'h55), 5'd7, 0);
    step(0, 0, 0, 16'h0000, '0,          5'd0, 0);
    step(0, 0, 0, 16'h0000, '0,          5'd0, 1);
    chk("gated_ctrl_bubble",  DW'(ctrl_g), DW'(0));
    chk("ungated_ctrl_keeps", DW'(ctrl_u), DW'(16'h0005));
    chk("addr_keeps_last",    DW'(addr_g), DW'(5'd7));

    // Mid-stall reset with S full.
    step(0, 0, 1, 16'h0101, DW'(32'h101), 5'd3, 0);
    step(0, 0, 1, 16'h0202, DW'(32'h202), 5'd4, 0);
    step(1, 0, 0, 16'h0000, '0,           5'd0, 0);

    // Random traffic against the FIFO model.
    for (int i = 0; i < 10000; i++) begin
      logic rst, fl;
      rst = ($urandom_range(0, 511) == 0);
      fl  = ($urandom_range(0, 63) == 0);
      step(rst, fl, 1'($urandom_range(0, 1)), 16'($urandom()), rdata(),
           5'($urandom()), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
